// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch stage.
// Default widths, the halt encoding and the instruction/address types live here.
package inst_prefetch_queue_pkg;

  localparam int          INST_W_DEF    = 16;
  localparam int          ADDR_W_DEF    = 8;
  localparam logic [15:0] HALT_INST_DEF = 16'hFFFF;

  typedef logic [INST_W_DEF-1:0] inst_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Memory fetch, redirect and decode-side signals of the prefetch stage.
// The master side is the prefetch queue; the slave side is memory plus Decode.
interface inst_prefetch_queue_if
  import inst_prefetch_queue_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              halt_fetched;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, halt_fetched,
    input  imem_rdata, flush, flush_addr, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, halt_fetched,
    output imem_rdata, flush, flush_addr, out_ready
  );
endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// Circular queue of {inst, pc} entries with push, pop and a clear that wins.
// Reads are combinational so a captured word is visible in the next cycle.
module prefetch_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  // Per-entry write enables; storage carries no reset.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && !clear && (wr_q == AW'(gi))) begin
        mem_q[gi] <= push_data;
      end
    end
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[rd_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);
endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage: sequential fetch ahead of Decode into a queue,
// redirect on flush with stale-response discard, and stop after the halt word.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int                INST_W    = INST_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [INST_W-1:0] HALT_INST = HALT_INST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic              halted_q, halted_d;

  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              empty;
  logic              resp_valid, halt_hit, issue, push, pop;

  assign resp_valid = inflight_q && !drop_q;
  assign halt_hit   = resp_valid && (bus.imem_rdata == HALT_INST);

  // The halt word arriving this cycle already blocks the next request, so
  // nothing beyond the halt address is ever fetched. A pop is not credited.
  assign issue = rst && !halted_q && !halt_hit && !bus.flush
                 && ((count + CW'(inflight_q)) < CW'(DEPTH));

  assign push = resp_valid && !bus.flush;
  assign pop  = !empty && bus.out_ready && !bus.flush;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    inflight_d = 1'b0;
    drop_d     = 1'b0;
    halted_d   = halted_q;
    if (bus.flush) begin
      fetch_pc_d = bus.flush_addr;
      drop_d     = inflight_q;
      halted_d   = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        req_addr_d = fetch_pc_q;
      end
      if (halt_hit) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  prefetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .clear     (bus.flush),
    .push      (push),
    .push_data ({bus.imem_rdata, req_addr_q}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .empty     (empty)
  );

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = issue ? fetch_pc_q : '0;
  assign bus.out_valid    = !empty;
  assign bus.out_inst     = empty ? '0 : head[EW-1:ADDR_W];
  assign bus.out_pc       = empty ? '0 : head[ADDR_W-1:0];
  assign bus.halt_fetched = halted_q;
endmodule
